// File: rtl/mul_arb_pkg.sv
// Shared types and sizing helpers for the shared-multiplier arbiter.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Index width, never below one bit so single-bit counters stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Watchdog must reach TIMEOUT-1.
  function automatic int wd_width(input int timeout);
    return clog2(timeout);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_i wins.
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req_i,
  input  logic [clog2(NREQ)-1:0] last_i,
  output logic [NREQ-1:0]        gnt_oh_o,
  output logic [clog2(NREQ)-1:0] gnt_idx_o,
  output logic                   any_o
);

  localparam int IW = clog2(NREQ);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(last_i) + i) % NREQ);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        gnt_idx_o     = idx;
        gnt_oh_o[idx] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one multi-cycle multiplier among NREQ clients,
// one transaction in flight, with a watchdog that turns a hung multiply into an error response.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic              mul_done,
  input  logic [W-1:0]      mul_prod
);

  localparam int              IW       = clog2(NREQ);
  localparam int              WD_W     = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [W-1:0]    mul_a_q, mul_a_d;
  logic [W-1:0]    mul_b_q, mul_b_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            rsp_hs;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i     (req_valid),
    .last_i    (last_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  assign rsp_hs = (state_q == S_RESP) && rsp_ready[grant_q];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Done is checked before expiry so a result on the last watchdog cycle is kept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_any) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mul_done || (wd_q == WD_LAST)) state_d = S_RESP;
      S_RESP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    last_d     = last_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wd_d       = wd_q;
    case (state_q)
      S_IDLE: if (pick_any) begin
        mul_a_d = req_a[pick_idx*W +: W];
        mul_b_d = req_b[pick_idx*W +: W];
        grant_d = pick_idx;
      end
      S_ISSUE: wd_d = '0;
      S_WAIT: begin
        if (mul_done) begin
          rsp_data_d = mul_prod;
          rsp_err_d  = 1'b0;
        end else if (wd_q == WD_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RESP: if (rsp_hs) last_d = grant_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      last_q     <= LAST_RST;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wd_q       <= '0;
    end else begin
      grant_q    <= grant_d;
      last_q     <= last_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wd_q       <= wd_d;
    end
  end

  // req_ready is masked during reset so no client sees a phantom accept.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE:  if (!rst) req_ready = pick_oh;
      S_ISSUE: mul_start = 1'b1;
      S_RESP:  rsp_valid[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: behavioural multiplier plus a transaction-level
// model of round-robin order, latency, timeout and reset behaviour.
module tb_mul_share_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      rsp_data, mul_a, mul_b, mul_prod;
  logic              rsp_err, mul_start, mul_done;

  always #5 clk = ~clk;

  mul_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_prod(mul_prod)
  );

  int       checks = 0;
  int       errors = 0;
  int       mlast;
  int       cyc = 0;
  int       last_accept = 0;
  int       m_delay = 0;
  int       m_cnt = 0;
  logic [W-1:0] m_p;
  bit       force_done = 1'b0;

  // Round-robin reference: first requester after the last granted one.
  function automatic int rr_next(input int last, input logic [NREQ-1:0] m);
    for (int i = 1; i <= NREQ; i++) begin
      if (m[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  // Advance one cycle; the multiplier model raises done m_delay cycles after start.
  task automatic tick();
    logic [2*W-1:0] full;
    if (mul_start === 1'b1) begin
      m_cnt = m_delay;
      full  = mul_a * mul_b;
      m_p   = full[W-1:0];
    end
    @(posedge clk);
    #1;
    cyc++;
    mul_done = force_done;
    mul_prod = force_done ? W'($urandom) : '0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mul_done = 1'b1;
        mul_prod = m_p;
      end
    end
  endtask

  task automatic rand_ops(output logic [NREQ*W-1:0] av, output logic [NREQ*W-1:0] bv);
    for (int i = 0; i < NREQ; i++) begin
      av[i*W +: W] = W'($urandom);
      bv[i*W +: W] = W'($urandom);
    end
  endtask

  // One full transaction from an IDLE cycle; k=0 means the multiplier hangs.
  task automatic do_txn(input logic [NREQ-1:0] vmask, input logic [NREQ*W-1:0] av,
                        input logic [NREQ*W-1:0] bv, input int k, input int bp, output int win);
    int             ew, c, exp_c;
    logic [W-1:0]   ea, eb, ed;
    logic [2*W-1:0] full;
    logic [NREQ-1:0] eoh, rr;
    logic           exp_err;
    bit             bad;
    ew      = rr_next(mlast, vmask);
    ea      = av[ew*W +: W];
    eb      = bv[ew*W +: W];
    full    = ea * eb;
    exp_err = (k == 0);
    ed      = exp_err ? '0 : full[W-1:0];
    exp_c   = exp_err ? TIMEOUT + 2 : 2 + k;
    eoh     = '0;
    eoh[ew] = 1'b1;
    m_delay = k;
    req_valid = vmask; req_a = av; req_b = bv; rsp_ready = '0;
    #1;
    last_accept = cyc;
    checks++;
    if (req_ready !== eoh) begin
      errors++; $display("FAIL accept_grant: req_ready=%b expected %b", req_ready, eoh);
    end
    tick(); c = 1;
    checks++;
    if (mul_start !== 1'b1 || mul_a !== ea || mul_b !== eb || req_ready !== '0) begin
      errors++;
      $display("FAIL issue: start=%b a=%h b=%h ready=%b expected start=1 a=%h b=%h ready=0",
               mul_start, mul_a, mul_b, req_ready, ea, eb);
    end
    bad = 1'b0;
    while (c < TIMEOUT + 20) begin
      tick(); c++;
      if (rsp_valid !== '0) break;
      if (mul_start !== 1'b0 || req_ready !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL wait_quiet: extra start or ready while waiting, expected none"); end
    checks++;
    if (c != exp_c) begin errors++; $display("FAIL rsp_latency: rsp at cycle %0d expected %0d", c, exp_c); end
    checks++;
    if (rsp_valid !== eoh || rsp_data !== ed || rsp_err !== exp_err) begin
      errors++;
      $display("FAIL rsp: valid=%b data=%h err=%b expected valid=%b data=%h err=%b",
               rsp_valid, rsp_data, rsp_err, eoh, ed, exp_err);
    end
    bad = 1'b0;
    for (int i = 0; i < bp; i++) begin
      rr = NREQ'($urandom);
      rsp_ready = rr & ~eoh;
      force_done = 1'b1;
      tick();
      if (rsp_valid !== eoh || rsp_data !== ed || rsp_err !== exp_err ||
          req_ready !== '0 || mul_start !== 1'b0) bad = 1'b1;
    end
    force_done = 1'b0;
    if (bp > 0) begin
      checks++;
      if (bad) begin errors++; $display("FAIL rsp_hold: response changed under backpressure, expected stable"); end
    end
    rr = NREQ'($urandom);
    rsp_ready = rr | eoh;
    tick();
    rsp_ready = '0;
    req_valid = '0;
    mlast = ew;
    win = ew;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0; force_done = 1'b0; m_cnt = 0;
    tick(); tick();
    rst = 1'b0;
    mlast = NREQ - 1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || mul_start !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ready=%b valid=%b start=%b expected all 0", req_ready, rsp_valid, mul_start);
    end
    checks++;
    if (mul_a !== '0 || mul_b !== '0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_data: a=%h b=%h data=%h err=%b expected all 0", mul_a, mul_b, rsp_data, rsp_err);
    end
  endtask

  task automatic test_single();
    logic [NREQ*W-1:0] av, bv;
    int w;
    rand_ops(av, bv);
    av[2*W +: W] = 16'd7;
    bv[2*W +: W] = 16'd6;
    do_txn(4'b0100, av, bv, 5, 0, w);
  endtask

  task automatic test_fairness();
    logic [NREQ*W-1:0] av, bv;
    int w;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      rand_ops(av, bv);
      do_txn(4'b1111, av, bv, $urandom_range(1, 6), 0, w);
      checks++;
      if (w != i % NREQ) begin errors++; $display("FAIL fair_order: txn %0d granted %0d expected %0d", i, w, i % NREQ); end
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ*W-1:0] av, bv;
    int w;
    rand_ops(av, bv);
    do_txn(4'b1110, av, bv, 3, 10, w);
    checks++;
    if (w != 1) begin errors++; $display("FAIL bp_grant: granted %0d expected 1", w); end
    rand_ops(av, bv);
    do_txn(4'b1110, av, bv, 2, 0, w);
  endtask

  task automatic test_back_to_back();
    logic [NREQ*W-1:0] av, bv;
    int w, first;
    rand_ops(av, bv);
    do_txn(4'b1111, av, bv, 1, 0, w);
    first = last_accept;
    rand_ops(av, bv);
    do_txn(4'b1111, av, bv, 1, 0, w);
    checks++;
    if (last_accept - first != 4) begin
      errors++; $display("FAIL turnaround: %0d cycles between accepts expected 4", last_accept - first);
    end
  endtask

  task automatic test_timeout();
    logic [NREQ*W-1:0] av, bv;
    logic [NREQ-1:0] m;
    int w;
    rand_ops(av, bv);
    m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    do_txn(m, av, bv, 0, $urandom_range(0, 3), w);
    rand_ops(av, bv);
    do_txn(4'b1111, av, bv, 4, 0, w);
  endtask

  task automatic test_stale_done();
    logic [NREQ*W-1:0] av, bv;
    bit bad;
    int w;
    req_valid = '0;
    force_done = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid !== '0 || mul_start !== 1'b0 || req_ready !== '0) bad = 1'b1;
    end
    force_done = 1'b0;
    tick();
    checks++;
    if (bad) begin errors++; $display("FAIL stale_idle: activity seen with done high in IDLE, expected none"); end
    rand_ops(av, bv);
    do_txn(4'b0101, av, bv, 3, 0, w);
    rand_ops(av, bv);
    do_txn(4'b1111, av, bv, TIMEOUT, 0, w);
  endtask

  task automatic test_reset_mid();
    logic [NREQ*W-1:0] av, bv;
    bit bad;
    int w;
    rand_ops(av, bv);
    av[3*W +: W] = 16'h1234;
    bv[3*W +: W] = 16'h0011;
    m_delay = 0;
    req_valid = 4'b1000; req_a = av; req_b = bv;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_accept: req_ready=%b expected 1000", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cnt = 0;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || mul_start !== 1'b0 || mul_a !== '0 ||
        mul_b !== '0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b valid=%b start=%b a=%h b=%h data=%h err=%b expected all 0",
               req_ready, rsp_valid, mul_start, mul_a, mul_b, rsp_data, rsp_err);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid !== '0 || mul_start !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL mid_dropped: response after reset, expected none"); end
    mlast = NREQ - 1;
    rand_ops(av, bv);
    do_txn(4'b1001, av, bv, 2, 0, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL mid_priority: granted %0d expected 0", w); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    mul_done = 1'b0; mul_prod = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_stale_done();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle multiplier between NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and launches the multiplier with a one-cycle start pulse. It waits for the multiplier's done, then returns the product to the granted requester over a per-requester response handshake. A watchdog aborts a hung multiply with an error response. It sits between client logic and the multiplier datapath and its controller.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, operand and product width
- TIMEOUT, 1023, maximum cycles spent in WAIT before abort (≥ 2)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has an operand pair
- req_ready  out  NREQ  one-hot or zero; operand pair i accepted this cycle
- req_a  in  NREQ*W  operand A; requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B; same packing
- rsp_valid  out  NREQ  one-hot or zero; result for requester i
- rsp_ready  in  NREQ  requester i takes its result
- rsp_data  out  W  product (low W bits); 0 on error
- rsp_err  out  1  result is a timeout abort
- mul_start  out  1  one-cycle launch pulse to the multiplier
- mul_a, mul_b  out  W each  operands to the multiplier, held stable from start to done
- mul_done  in  1  multiplier result valid (level or pulse)
- mul_prod  in  W  multiplier result

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick the winner round-robin, starting at (last_grant+1) mod NREQ. Assert req_ready[winner] combinationally this cycle. Register req_a/req_b of the winner into mul_a/mul_b. Record grant. Go to ISSUE. With no req_valid, stay in IDLE.
- ISSUE: mul_start=1 for exactly this cycle. Clear the watchdog. Go to WAIT.
- WAIT: when mul_done=1, capture mul_prod into rsp_data, set rsp_err=0, go to RESP. Otherwise increment the watchdog. When the watchdog reaches TIMEOUT-1 without done, set rsp_data=0, rsp_err=1, go to RESP.
- RESP: rsp_valid[grant]=1. rsp_data and rsp_err are held. On rsp_ready[grant], update last_grant=grant and go to IDLE. rsp_ready of other requesters is ignored.
- Only one transaction is in flight; req_ready is 0 outside IDLE.
- mul_done is ignored outside WAIT. A stale done in IDLE, ISSUE or RESP has no effect.
- mul_done and watchdog expiry in the same cycle: done wins, rsp_err=0.
- A requester may drop req_valid before it is granted; no state changes.
- Products wider than W are the multiplier's concern; the arbiter forwards mul_prod unchanged.

## Timing
- Reset values: state IDLE, all req_ready/rsp_valid 0, mul_start 0, mul_a/mul_b 0, rsp_data 0, rsp_err 0, watchdog 0, last_grant NREQ-1 (requester 0 has first priority).
- Reset mid-operation returns to IDLE next cycle and drops the in-flight transaction with no response. The multiplier is expected to be reset alongside.
- Latency:
  - Accept at cycle 0; mul_start at cycle 1.
  - If mul_done first rises at cycle 1+k (k ≥ 1), rsp_valid rises at cycle 2+k.
  - With rsp_ready already high, IDLE is re-entered at cycle 3+k. The earliest next accept is that cycle.
- Minimum turnaround between accepts is 4 cycles (k=1, immediate rsp_ready).
- Timeout: rsp_valid with rsp_err=1 rises exactly TIMEOUT+2 cycles after accept.

## Structure
- Package mul_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP) with 2-bit encoding
  - grant-index width function clog2(NREQ)
  - watchdog width constant derived from TIMEOUT
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: NREQ request vector, last-grant index.
  - Outputs: one-hot grant, grant index, any-valid flag.
- The FSM, operand/result registers and watchdog live in mul_share_arbiter.

## Test plan
- Single request: req_valid[2]=1 with a=7, b=6; multiplier model raises done 5 cycles after start with 42. Required: req_ready[2] at cycle 0, mul_start at cycle 1, rsp_valid[2] with rsp_data=42, rsp_err=0 at cycle 7.
- Fairness: all four req_valid held high, 8 transactions. Required grant order 0,1,2,3,0,1,2,3.
- Response backpressure: rsp_ready[1] held low 10 cycles. Required: rsp_valid[1] and rsp_data stable, no req_ready to anyone, then a return to IDLE one cycle after rsp_ready[1]=1.
- Timeout: TIMEOUT=8, multiplier never raises done. Required: rsp_valid with rsp_err=1, rsp_data=0 exactly 10 cycles after accept. The next request is serviced normally.
- Stale and simultaneous done:
  - mul_done forced high in IDLE: no state change.
  - done at the watchdog's last cycle: rsp_err=0 with the product returned.
- Reset at the 3rd WAIT cycle: all outputs at reset values next cycle. Requester 0 wins the next arbitration even if requester 3 also requests.
